// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock qualification sequencer with timeout, bounded retries and SDRAM-domain reset release.
// Ports:
//   clk         in   50 MHz reference clock (same net as PLL refclk)
//   reset_n     in   asynchronous active-low reset
//   pll_locked  in   PLL locked, asynchronous to clk
//   soft_reset  in   one-cycle synchronous restart request
//   pll_rst     out  active-high PLL reset
//   sys_reset_n out  active-low reset to SDRAM-clock logic
//   ready       out  high in RUN
//   fail        out  high in FAIL
//   retry_cnt   out  attempts consumed, saturates at MAX_RETRIES
//   state       out  RESET_PLL=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAIL=4
// Optional feature: define PLL_SEQ_AUTO_RETRY_EN to re-sequence on lock loss in RUN
// instead of going straight to FAIL.
module pll_lock_sequencer #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } st_t;
  st_t st, nxt;
  logic             s1, locked_s;
  logic [CNT_W-1:0] cnt, cnt_n, stab, stab_n;
  logic [1:0]       retry_n;
  logic             timeout, can_retry;
`ifdef PLL_SEQ_AUTO_RETRY_EN
  logic [15:0]      run_cnt, run_n;
`endif
  // cnt is the hold counter in RESET_PLL and the per-attempt timeout in
  // WAIT_LOCK/STABLE; it is deliberately not cleared on STABLE->WAIT_LOCK so
  // repeated lock glitches cannot extend an attempt beyond the timeout.
  assign timeout   = cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  assign can_retry = retry_cnt < 2'(MAX_RETRIES);
  always_comb begin
    nxt     = st;
    cnt_n   = cnt;
    stab_n  = stab;
    retry_n = retry_cnt;
`ifdef PLL_SEQ_AUTO_RETRY_EN
    run_n   = '0;
`endif
    case (st)
      RESET_PLL: begin
        nxt   = cnt == CNT_W'(RST_HOLD_CYCLES - 1) ? WAIT_LOCK : RESET_PLL;
        cnt_n = cnt == CNT_W'(RST_HOLD_CYCLES - 1) ? '0 : cnt + 1'b1;
      end
      WAIT_LOCK, STABLE: begin
        // Timeout outranks a lock rise or stable completion on the same edge.
        if (timeout) begin
          nxt     = can_retry ? RESET_PLL : FAILED;
          cnt_n   = can_retry ? '0 : cnt;
          retry_n = can_retry ? retry_cnt + 1'b1 : retry_cnt;
        end else begin
          cnt_n = cnt + 1'b1;
          if (st == WAIT_LOCK) begin
            nxt    = locked_s ? STABLE : WAIT_LOCK;
            stab_n = '0;
          end else if (!locked_s) begin
            nxt = WAIT_LOCK;
          end else if (stab == CNT_W'(LOCK_STABLE_CYCLES)) begin
            nxt = RUN;
          end else begin
            stab_n = stab + 1'b1;
          end
        end
      end
      RUN: begin
`ifdef PLL_SEQ_AUTO_RETRY_EN
        run_n   = run_cnt == 16'hFFFF ? run_cnt : run_cnt + 1'b1;
        retry_n = run_cnt == 16'hFFFF ? 2'd0 : retry_cnt;
        if (!locked_s) begin
          nxt     = can_retry ? RESET_PLL : FAILED;
          cnt_n   = '0;
          retry_n = can_retry ? retry_cnt + 1'b1 : retry_cnt;
        end
`else
        nxt = locked_s ? RUN : FAILED;
`endif
      end
      FAILED: nxt = FAILED;
      default: begin
        nxt   = RESET_PLL;
        cnt_n = '0;
      end
    endcase
    if (soft_reset) begin
      nxt     = RESET_PLL;
      cnt_n   = '0;
      stab_n  = '0;
      retry_n = '0;
    end
  end
  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1          <= 1'b0;
      locked_s    <= 1'b0;
      st          <= RESET_PLL;
      cnt         <= '0;
      stab        <= '0;
      retry_cnt   <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      fail        <= 1'b0;
      state       <= 3'd0;
`ifdef PLL_SEQ_AUTO_RETRY_EN
      run_cnt     <= '0;
`endif
    end else begin
      s1          <= pll_locked;
      locked_s    <= s1;
      st          <= nxt;
      cnt         <= cnt_n;
      stab        <= stab_n;
      retry_cnt   <= retry_n;
      pll_rst     <= nxt == RESET_PLL || nxt == FAILED;
      sys_reset_n <= nxt == RUN;
      ready       <= nxt == RUN;
      fail        <= nxt == FAILED;
      state       <= nxt;
`ifdef PLL_SEQ_AUTO_RETRY_EN
      run_cnt     <= run_n;
`endif
    end
  end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;
  logic       clk = 1'b0;
  logic       reset_n, pll_locked, soft_reset;
  logic       pll_rst, sys_reset_n, ready, fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;
  int         total = 0;
  int         bad = 0;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(2),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .soft_reset(soft_reset),
    .pll_rst(pll_rst),
    .sys_reset_n(sys_reset_n),
    .ready(ready),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic pr,
                         input logic sr, input logic rd, input logic fl, input logic [1:0] rc);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(pr));
    chk({tag, ".sys_reset_n"}, 32'(sys_reset_n), 32'(sr));
    chk({tag, ".ready"}, 32'(ready), 32'(rd));
    chk({tag, ".fail"}, 32'(fail), 32'(fl));
    chk({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(rc));
  endtask

  task automatic pulse_soft;
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    pll_locked = 1'b0;
    soft_reset = 1'b0;
    tick(3);
    chk_out("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    reset_n = 1'b1;
    // Nominal: pll_rst held for exactly 4 edges.
    tick(3);
    chk_out("hold3", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
    chk_out("wait_entry", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(6);
    pll_locked = 1'b1;
    tick(2);
    chk("nom_sync_lag.state", 32'(state), 32'd1);
    tick(1);
    chk("nom_stable_entry.state", 32'(state), 32'd2);
    tick(8);
    chk_out("nom_pre_release", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
    chk_out("nom_release", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    // Lock loss in RUN.
    pll_locked = 1'b0;
    tick(2);
    chk_out("loss_2edges", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    tick(1);
`ifdef PLL_SEQ_AUTO_RETRY_EN
    chk_out("loss_resequence", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
`else
    chk_out("loss_fail", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    tick(5);
    chk_out("fail_held", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
`endif
    // soft_reset, then never lock: three attempts then FAIL.
    pulse_soft();
    chk_out("soft_from_loss", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(35);
    chk_out("nl_pre_to1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
    chk_out("nl_retry1", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    tick(3);
    chk("nl_hold2.pll_rst", 32'(pll_rst), 32'd1);
    tick(1);
    chk_out("nl_wait2", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    tick(31);
    chk("nl_pre_to2.state", 32'(state), 32'd1);
    tick(1);
    chk_out("nl_retry2", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    tick(35);
    chk_out("nl_pre_to3", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    tick(1);
    chk_out("nl_fail", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    // soft_reset in FAIL, then a full nominal sequence.
    pulse_soft();
    chk_out("soft_in_fail", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(4);
    chk("renom_wait.state", 32'(state), 32'd1);
    pll_locked = 1'b1;
    tick(11);
    chk("renom_pre.ready", 32'(ready), 32'd0);
    tick(1);
    chk_out("renom_run", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    // soft_reset in RUN (lock still high).
    pulse_soft();
    chk_out("soft_in_run", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(16);
    chk_out("run_again", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    // Glitchy lock: high 5, low 1, high.
    pll_locked = 1'b0;
    pulse_soft();
    tick(4);
    chk("gl_wait.state", 32'(state), 32'd1);
    tick(2);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    chk("gl_still_stable.state", 32'(state), 32'd2);
    tick(1);
    chk_out("gl_back_to_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(9);
    chk_out("gl_pre_release", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
    chk_out("gl_release", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    // Async reset mid-STABLE, between edges.
    pulse_soft();
    tick(5);
    chk("ar_in_stable.state", 32'(state), 32'd2);
    reset_n = 1'b0;
    #2;
    chk_out("async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
